// File: rtl/execute_md.sv
// execute_md: RV32M-capable execute stage.
// Single-cycle ALU with operand forwarding and branch/jump resolution, plus a
// multi-cycle multiply/divide unit that freezes the front end through BusyH.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   PCC..RData2C, control *C        C-stage operands and control
//   ForwardAH/BH, Forward*H         forwarding selects and data
//   BusyH                           mul/div in progress (front-end freeze)
//   PCSrcA, PCTargetA               redirect request and target
//   *D                              D-stage pipeline register outputs
module execute_md #(
  parameter int DATA_WIDTH    = 32,
  parameter int MUL_STAGES    = 2,
  parameter int DIV_EARLY_OUT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] PCC,
  input  logic [DATA_WIDTH-1:0] PCPlus4C,
  input  logic [DATA_WIDTH-1:0] ImmExtC,
  input  logic [DATA_WIDTH-1:0] RData1C,
  input  logic [DATA_WIDTH-1:0] RData2C,
  input  logic                  RegWriteC,
  input  logic                  MemWriteC,
  input  logic                  JumpC,
  input  logic                  BranchC,
  input  logic                  LinkRegCtrlC,
  input  logic                  MulDivC,
  input  logic                  FlushC,
  input  logic [1:0]            ALUSrcC,
  input  logic [1:0]            ResultSrcC,
  input  logic [3:0]            ALUCtrlC,
  input  logic [2:0]            Funct3C,
  input  logic [4:0]            RdC,
  input  logic [1:0]            ForwardAH,
  input  logic [1:0]            ForwardBH,
  input  logic [DATA_WIDTH-1:0] ForwardALUResultDH,
  input  logic [DATA_WIDTH-1:0] ForwardWriteResultEH,
  output logic                  BusyH,
  output logic                  PCSrcA,
  output logic [DATA_WIDTH-1:0] PCTargetA,
  output logic                  RegWriteD,
  output logic                  MemWriteD,
  output logic [1:0]            ResultSrcD,
  output logic [4:0]            RdD,
  output logic [2:0]            Funct3D,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic [DATA_WIDTH-1:0] ALUResultD,
  output logic [DATA_WIDTH-1:0] MemWriteDataD
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'((MUL_STAGES > 3) ? (MUL_STAGES - 3) : 0);
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // One restoring-division step: returns {remainder, quotient} after shifting in one bit.
  function automatic logic [2*DATA_WIDTH-1:0] div_step(
    input logic [DATA_WIDTH-1:0] rem,
    input logic [DATA_WIDTH-1:0] quo,
    input logic [DATA_WIDTH-1:0] dvs
  );
    logic [DATA_WIDTH:0] sh;
    logic [DATA_WIDTH:0] trial;
    sh    = {rem, quo[DATA_WIDTH-1]};
    trial = sh - {1'b0, dvs};
    if (trial[DATA_WIDTH]) begin
      div_step = {sh[DATA_WIDTH-1:0], quo[DATA_WIDTH-2:0], 1'b0};
    end else begin
      div_step = {trial[DATA_WIDTH-1:0], quo[DATA_WIDTH-2:0], 1'b1};
    end
  endfunction

  logic [DATA_WIDTH-1:0]   fwd_a_s, fwd_b_s, alu_a_s, alu_b_s, alu_res_s;
  logic [DATA_WIDTH-1:0]   tgt_sum_s;
  logic                    taken_s;
  logic [1:0]              state_r;
  logic [CW-1:0]           cnt_r;
  logic [DATA_WIDTH-1:0]   a_r, b_r, quo_r, rem_r, pc4_r;
  logic [2:0]              f3_r;
  logic [4:0]              rd_r;
  logic                    neg_q_r, neg_r_r, dz_r, ovf_r;
  logic                    start_s, mul_now_s, busy_s;
  logic [DATA_WIDTH-1:0]   mop_a_s, mop_b_s, mul_res_s;
  logic [2:0]              mop_f3_s;
  logic [2*DATA_WIDTH-1:0] mext_a_s, mext_b_s, prod_s;
  logic                    div_signed_s, a_neg_s, b_neg_s, dz_s, ovf_s;
  logic [DATA_WIDTH-1:0]   a_mag_s, b_mag_s, q_fix_s, r_fix_s, div_res_s, done_res_s;
  logic [2*DATA_WIDTH-1:0] first_step_s, next_step_s;

  assign fwd_a_s = (ForwardAH == 2'b10) ? ForwardALUResultDH :
                   (ForwardAH == 2'b01) ? ForwardWriteResultEH : RData1C;
  assign fwd_b_s = (ForwardBH == 2'b10) ? ForwardALUResultDH :
                   (ForwardBH == 2'b01) ? ForwardWriteResultEH : RData2C;
  assign alu_a_s = ALUSrcC[1] ? PCC : fwd_a_s;
  assign alu_b_s = ALUSrcC[0] ? ImmExtC : fwd_b_s;

  // Single-cycle ALU.
  always_comb begin
    alu_res_s = '0;
    case (ALUCtrlC)
      4'd0:    alu_res_s = alu_a_s + alu_b_s;
      4'd1:    alu_res_s = alu_a_s - alu_b_s;
      4'd2:    alu_res_s = alu_a_s ^ alu_b_s;
      4'd3:    alu_res_s = alu_a_s | alu_b_s;
      4'd4:    alu_res_s = alu_a_s & alu_b_s;
      4'd5:    alu_res_s = alu_a_s << alu_b_s[SW-1:0];
      4'd6:    alu_res_s = alu_a_s >> alu_b_s[SW-1:0];
      4'd7:    alu_res_s = $unsigned($signed(alu_a_s) >>> alu_b_s[SW-1:0]);
      4'd8:    alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(alu_a_s) < $signed(alu_b_s))};
      4'd9:    alu_res_s = {{(DATA_WIDTH-1){1'b0}}, (alu_a_s < alu_b_s)};
      4'd10:   alu_res_s = alu_b_s;
      default: alu_res_s = '0;
    endcase
  end

  // Branch condition on forwarded operands.
  always_comb begin
    taken_s = 1'b0;
    case (Funct3C)
      3'b000:  taken_s = (fwd_a_s == fwd_b_s);
      3'b001:  taken_s = (fwd_a_s != fwd_b_s);
      3'b100:  taken_s = ($signed(fwd_a_s) < $signed(fwd_b_s));
      3'b101:  taken_s = ($signed(fwd_a_s) >= $signed(fwd_b_s));
      3'b110:  taken_s = (fwd_a_s < fwd_b_s);
      3'b111:  taken_s = (fwd_a_s >= fwd_b_s);
      default: taken_s = 1'b0;
    endcase
  end

  assign tgt_sum_s = (LinkRegCtrlC ? fwd_a_s : PCC) + ImmExtC;
  assign PCTargetA = LinkRegCtrlC ? {tgt_sum_s[DATA_WIDTH-1:1], 1'b0} : tgt_sum_s;
  assign PCSrcA    = ~FlushC & (JumpC | (BranchC & taken_s));

  // Start of an M-op; single-stage multiplies finish in place without stalling.
  assign start_s   = (state_r == ST_IDLE) & MulDivC & ~FlushC;
  assign mul_now_s = start_s & ~Funct3C[2] & (MUL_STAGES == 1);
  assign busy_s    = (start_s & ~mul_now_s) |
                     (((state_r == ST_MUL) | (state_r == ST_DIV)) & ~FlushC);
  assign BusyH     = busy_s;

  // Multiplier reads live operands only when finishing in the start cycle.
  assign mop_a_s  = (state_r == ST_IDLE) ? fwd_a_s : a_r;
  assign mop_b_s  = (state_r == ST_IDLE) ? fwd_b_s : b_r;
  assign mop_f3_s = (state_r == ST_IDLE) ? Funct3C : f3_r;
  // MULH and MULHSU treat A as signed; only MULH treats B as signed.
  assign mext_a_s = {{DATA_WIDTH{mop_a_s[DATA_WIDTH-1] & ((mop_f3_s == 3'd1) | (mop_f3_s == 3'd2))}}, mop_a_s};
  assign mext_b_s = {{DATA_WIDTH{mop_b_s[DATA_WIDTH-1] & (mop_f3_s == 3'd1)}}, mop_b_s};
  assign prod_s    = mext_a_s * mext_b_s;
  assign mul_res_s = (mop_f3_s[1:0] == 2'd0) ? prod_s[DATA_WIDTH-1:0] : prod_s[2*DATA_WIDTH-1:DATA_WIDTH];

  // Divider setup: magnitudes, sign fix-up flags and special cases.
  assign div_signed_s = ~Funct3C[0];
  assign a_neg_s      = div_signed_s & fwd_a_s[DATA_WIDTH-1];
  assign b_neg_s      = div_signed_s & fwd_b_s[DATA_WIDTH-1];
  assign a_mag_s      = a_neg_s ? (-fwd_a_s) : fwd_a_s;
  assign b_mag_s      = b_neg_s ? (-fwd_b_s) : fwd_b_s;
  assign dz_s         = (fwd_b_s == '0);
  assign ovf_s        = div_signed_s & (fwd_a_s == MIN_VAL) & (fwd_b_s == {DATA_WIDTH{1'b1}});
  assign first_step_s = div_step('0, a_mag_s, b_mag_s);
  assign next_step_s  = div_step(rem_r, quo_r, b_r);

  assign q_fix_s    = neg_q_r ? (-quo_r) : quo_r;
  assign r_fix_s    = neg_r_r ? (-rem_r) : rem_r;
  assign div_res_s  = dz_r  ? (f3_r[1] ? a_r : {DATA_WIDTH{1'b1}}) :
                      ovf_r ? (f3_r[1] ? '0 : MIN_VAL) :
                      (f3_r[1] ? r_fix_s : q_fix_s);
  assign done_res_s = f3_r[2] ? div_res_s : mul_res_s;

  // M-op FSM and operand/divider state; a flush aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      quo_r   <= '0;
      rem_r   <= '0;
      pc4_r   <= '0;
      f3_r    <= 3'd0;
      rd_r    <= 5'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (FlushC) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            a_r     <= fwd_a_s;
            f3_r    <= Funct3C;
            rd_r    <= RdC;
            pc4_r   <= PCPlus4C;
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            dz_r    <= dz_s;
            ovf_r   <= ovf_s;
            if (!Funct3C[2]) begin
              // Multiply keeps the raw B operand.
              b_r   <= fwd_b_s;
              cnt_r <= '0;
              if (MUL_STAGES == 1) begin
                state_r <= ST_IDLE;
              end else if (MUL_STAGES == 2) begin
                state_r <= ST_DONE;
              end else begin
                state_r <= ST_MUL;
              end
            end else begin
              // Divide keeps |B| as divisor; the first iteration runs this cycle.
              b_r   <= b_mag_s;
              {rem_r, quo_r} <= first_step_s;
              cnt_r <= CW'(1);
              if ((DIV_EARLY_OUT != 0) && (dz_s || ovf_s)) begin
                state_r <= ST_DONE;
              end else begin
                state_r <= ST_DIV;
              end
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_r == MUL_LAST) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DIV: begin
          {rem_r, quo_r} <= next_step_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == DIV_LAST) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // D-stage pipeline register: bubble on flush/stall, M-op result in DONE, else ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteD     <= 1'b0;
      MemWriteD     <= 1'b0;
      ResultSrcD    <= 2'd0;
      RdD           <= 5'd0;
      Funct3D       <= 3'd0;
      PCPlus4D      <= '0;
      ALUResultD    <= '0;
      MemWriteDataD <= '0;
    end else if (FlushC || busy_s) begin
      RegWriteD  <= 1'b0;
      MemWriteD  <= 1'b0;
      ResultSrcD <= 2'd0;
      RdD        <= 5'd0;
    end else if (state_r == ST_DONE) begin
      RegWriteD  <= RegWriteC;
      MemWriteD  <= 1'b0;
      ResultSrcD <= ResultSrcC;
      RdD        <= rd_r;
      Funct3D    <= f3_r;
      PCPlus4D   <= pc4_r;
      ALUResultD <= done_res_s;
    end else begin
      RegWriteD     <= RegWriteC;
      MemWriteD     <= MemWriteC & ~MulDivC;
      ResultSrcD    <= ResultSrcC;
      RdD           <= RdC;
      Funct3D       <= Funct3C;
      PCPlus4D      <= PCPlus4C;
      ALUResultD    <= mul_now_s ? mul_res_s : alu_res_s;
      MemWriteDataD <= fwd_b_s;
    end
  end

endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
Execute stage with RV32M support. It keeps single-cycle ALU, forwarding and branch resolution, and adds a multi-cycle multiply/divide unit with a stall handshake to the hazard unit. It sits between the decode/C pipeline register and the memory (D) stage. Parametrised in data width, multiplier latency and divider early-out.

Parameters:
DATA_WIDTH, 32, operand/result width (multiple of 8, ≥16)
MUL_STAGES, 2, multiply latency in cycles (1..4)
DIV_EARLY_OUT, 1, 1 = divide-by-zero/overflow completes in 2 cycles instead of full iteration

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
PCC, PCPlus4C, ImmExtC, RData1C, RData2C  in  DATA_WIDTH each  C-stage operands
RegWriteC, MemWriteC, JumpC, BranchC, LinkRegCtrlC, MulDivC, FlushC  in  1 each  control; FlushC kills the C-stage instruction
ALUSrcC, ResultSrcC  in  2 each  ALU_A = PCC if ALUSrcC[1] else fwdA; ALU_B = ImmExtC if ALUSrcC[0] else fwdB
ALUCtrlC  in  4  0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 pass ALU_B; others give 0
Funct3C  in  3  branch condition, or M-op (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU = 0..7)
RdC  in  5  destination
ForwardAH, ForwardBH  in  2 each  10 = ForwardALUResultDH, 01 = ForwardWriteResultEH, else RData
ForwardALUResultDH, ForwardWriteResultEH  in  DATA_WIDTH each  forwarded data
BusyH  out  1  muldiv in progress; hazard unit freezes F/Dec/C while high
PCSrcA  out  1  redirect
PCTargetA  out  DATA_WIDTH  redirect target
RegWriteD, MemWriteD  out  1 each  D-stage register outputs
ResultSrcD  out  2  D-stage register output
RdD  out  5  D-stage register output
Funct3D  out  3  D-stage register output
PCPlus4D, ALUResultD, MemWriteDataD  out  DATA_WIDTH each  D-stage register outputs

Behaviour:
- Reset: state IDLE, counters cleared, all D outputs 0, BusyH 0.
- Non-M instruction (MulDivC=0): combinational ALU.
  - Shift amount is ALU_B[log2(DATA_WIDTH)-1:0].
  - SLT is signed; SLTU is unsigned.
  - Result registered into D at the next edge (latency 1).
  - MemWriteDataD = fwdB.
  - ResultSrcD = ResultSrcC.
- Branch: compare fwdA vs fwdB per Funct3C (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111); other codes give not-taken.
  - PCSrcA = ~FlushC & (JumpC | (BranchC & taken)).
  - PCTargetA = (LinkRegCtrlC ? fwdA : PCC) + ImmExtC, with bit0 forced to 0 when LinkRegCtrlC.
- M-op FSM states: IDLE, MUL, DIV, DONE.
  - Start: in IDLE with MulDivC=1 and FlushC=0, capture fwdA/fwdB and Funct3C, RdC, PCPlus4C. Go to MUL (Funct3C<4) or DIV.
  - BusyH is combinationally high in the start cycle and while in MUL/DIV. It is low in DONE.
  - After start, forwarding inputs are ignored.
  - MUL: 2*DATA_WIDTH product with signedness per op; MUL returns low half, others high half. Counter reaches DONE so the op occupies C for exactly MUL_STAGES cycles. MUL_STAGES=1 completes in the start cycle with no busy.
  - DIV: restoring, 1 quotient bit/cycle, DATA_WIDTH iterations, then DONE, for a total occupancy of DATA_WIDTH+1 cycles. Signed ops use magnitude division with sign fix-up (quotient negated if signs differ, remainder takes dividend sign).
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Signed overflow (MIN / -1): quotient MIN, remainder 0.
  - With DIV_EARLY_OUT=1, divide-by-zero and overflow go straight to DONE (2 cycles).
  - DONE: result loaded into D with captured RdC/PCPlus4C, RegWriteD=RegWriteC, MemWriteD=0, Funct3D=captured. Return to IDLE.
- While BusyH=1, every edge loads a bubble into D: RegWriteD=0, MemWriteD=0, ResultSrcD=0, RdD=0, data outputs hold.
- FlushC=1: D loaded with bubble; any in-flight op is aborted to IDLE at that edge. BusyH is 0 during the flush cycle.
- Async reset mid-operation: immediate return to reset values; no partial result is ever written.
- Upstream values on the C inputs while BusyH=1 are don't-care except FlushC.

Test Plan:
- ADD, RData1C=5 with ForwardAH=10 and ForwardALUResultDH=7, RData2C=3 -> next edge ALUResultD=10, RegWriteD=RegWriteC.
- MULHU 0xFFFFFFFF*2, MUL_STAGES=2 -> BusyH high 1 cycle with bubble in D, then ALUResultD=1. MUL on the same operands gives 0xFFFFFFFE.
- DIV -7/2 -> BusyH high 32 cycles, ALUResultD=0xFFFFFFFD at edge 33. REM gives 0xFFFFFFFF.
- DIVU 9/0 -> 0xFFFFFFFF after 2 cycles (EARLY_OUT=1). REMU 9/0 -> 9. DIV 0x80000000/-1 -> 0x80000000. REM -> 0.
- FlushC at cycle 10 of DIV -> BusyH=0 that cycle, RegWriteD=0, FSM in IDLE. rst_n low mid-MUL -> all D outputs 0 immediately.
- BLT fwdA=-1, fwdB=1, PCC=0x100, Imm=8 -> PCSrcA=1, PCTargetA=0x108. JALR fwdA=0x1003, Imm=4 -> PCTargetA=0x1006.
